// File: rtl/eth_rt_rx_filter_pkg.sv
// Shared constants, FSM encodings and the CRC step function for the GMII
// receive filter.
package eth_rt_rx_filter_pkg;

   localparam logic [31:0] CRC_SEED      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
   localparam int          MIN_FRAME_LEN = 64;
   localparam int          MAX_FRAME_LEN = 1522;
   localparam int          IPG_CYCLES    = 12;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam int PI_UNICAST   = 0;
   localparam int PI_MULTICAST = 1;
   localparam int PI_BROADCAST = 2;

   localparam int ERR_RXERR    = 0;
   localparam int ERR_CRC      = 1;
   localparam int ERR_LENGTH   = 2;
   localparam int ERR_OVERFLOW = 3;

   typedef enum logic [1:0] {W_IDLE, W_PRE, W_FRAME, W_DROP} wrState_t;
   typedef enum logic [1:0] {R_IDLE, R_SFD, R_DATA, R_GAP} rdState_t;

   // MSB-first CRC register fed LSB of each byte first, so the residue over
   // frame plus FCS is the bit-reversed form of the usual Ethernet constant.
   function automatic logic [31:0] crcNext(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_rt_rx_filter_crc32.sv
// Byte-wide Ethernet CRC32 accumulator; reseeded at SFD, advanced per stored byte.
module eth_rt_rx_filter_crc32
   import eth_rt_rx_filter_pkg::*;
(
   input  logic        clk,
   input  logic        resetActive,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   always_ff @(posedge clk) begin
      if (resetActive || init) crc <= CRC_SEED;
      else if (en)             crc <= crcNext(crc, data);
   end

endmodule

// File: rtl/eth_rt_rx_filter.sv
// Store-and-forward GMII receive filter: buffers frames, checks FCS/length/MAC,
// and replays accepted frames on a PortReady/RxValid byte handshake.
module eth_rt_rx_filter
   import eth_rt_rx_filter_pkg::*;
#(
   parameter int BUF_AW  = 11,
   parameter int DESC_AW = 2
) (
   input  logic        clk,
   input  logic        resetActive,
   input  logic        clearErrors,
   input  logic [47:0] macAddr,
   input  logic        phyRxValid,
   input  logic [7:0]  phyRxD,
   input  logic        phyRxErr,
   input  logic        PortReady,
   output logic        RxValid,
   output logic [7:0]  RxD,
   output logic        RxErr,
   output logic [3:0]  PacketInfo,
   output logic [7:0]  dropCount,
   output logic [3:0]  errFlags
);

   localparam int DEPTH      = 1 << BUF_AW;
   localparam int DESC_DEPTH = 1 << DESC_AW;

   typedef logic [BUF_AW-1:0] ptr_t;
   typedef struct packed {
      ptr_t        start;
      logic [10:0] len;
      logic [2:0]  cls;
   } desc_t;

   logic [7:0] bufMem [DEPTH];
   logic [7:0] bufQ;
   desc_t      descMem [DESC_DEPTH];
   desc_t      descQ;

   wrState_t wrState, wrStateNext;
   rdState_t rdState, rdStateNext;

   ptr_t        wptrReg, frameStartReg, rptrReg, rbaseReg;
   logic [10:0] nbytesReg, remainingReg;
   logic        ucastReg, bcastReg, mcastReg;
   logic [DESC_AW-1:0] descWrIdx, descRdIdx;
   logic [DESC_AW:0]   descCount;
   logic [3:0]  gapCount;
   logic        rxSfdReg;
   logic [31:0] crcValue;
   logic [7:0]  hitVec;

   logic descFull, bufFull, crcOk, lenOk;
   logic [2:0] frameCls;
   logic startFrame, storeByte, endFrame, acceptFrame, rejectFrame;
   logic dropOnErr, dropOnFull, countDrop, rewind;
   logic [3:0] flagSet;
   logic issueSfd, issueByte, popDesc;

   // Per-byte destination compare; the two padding lanes keep a 3-bit index in range.
   for (genvar gi = 0; gi < 8; gi++) begin : g_macHit
      if (gi < 6) begin : g_cmp
         assign hitVec[gi] = (phyRxD == macAddr[47-8*gi -: 8]);
      end else begin : g_pad
         assign hitVec[gi] = 1'b1;
      end
   end

   assign descFull = (descCount == (DESC_AW+1)'(DESC_DEPTH));
   assign bufFull  = (ptr_t'(wptrReg + 1'b1) == rbaseReg);
   assign crcOk    = (crcValue == CRC_RESIDUE);
   assign lenOk    = (nbytesReg >= 11'(MIN_FRAME_LEN)) && (nbytesReg <= 11'(MAX_FRAME_LEN));
   assign frameCls = {bcastReg, mcastReg & ~bcastReg, ucastReg & ~mcastReg};

   eth_rt_rx_filter_crc32 crcUnit (
      .clk         (clk),
      .resetActive (resetActive),
      .init        (startFrame),
      .en          (storeByte),
      .data        (phyRxD),
      .crc         (crcValue)
   );

   // ---------------- write FSM ----------------
   always_ff @(posedge clk) begin
      if (resetActive) wrState <= W_IDLE;
      else             wrState <= wrStateNext;
   end

   always_comb begin
      wrStateNext = wrState;
      case (wrState)
         W_IDLE:  if (phyRxValid) wrStateNext = W_PRE;
         W_PRE: begin
            if (!phyRxValid)                                  wrStateNext = W_IDLE;
            else if (phyRxErr || (phyRxD == SFD_BYTE && descFull)) wrStateNext = W_DROP;
            else if (phyRxD == SFD_BYTE)                      wrStateNext = W_FRAME;
         end
         W_FRAME: begin
            if (!phyRxValid)            wrStateNext = W_IDLE;
            else if (phyRxErr || bufFull) wrStateNext = W_DROP;
         end
         W_DROP:  if (!phyRxValid) wrStateNext = W_IDLE;
         default: wrStateNext = W_IDLE;
      endcase
   end

   always_comb begin
      startFrame  = (wrState == W_PRE) && phyRxValid && !phyRxErr && phyRxD == SFD_BYTE && !descFull;
      storeByte   = (wrState == W_FRAME) && phyRxValid && !phyRxErr && !bufFull;
      endFrame    = (wrState == W_FRAME) && !phyRxValid;
      acceptFrame = endFrame && crcOk && lenOk && (|frameCls);
      rejectFrame = endFrame && !acceptFrame;
      dropOnErr   = (wrState == W_PRE || wrState == W_FRAME) && phyRxValid && phyRxErr;
      dropOnFull  = phyRxValid && !phyRxErr &&
                    ((wrState == W_PRE && phyRxD == SFD_BYTE && descFull) ||
                     (wrState == W_FRAME && bufFull));
      countDrop   = dropOnErr || dropOnFull || rejectFrame;
      rewind      = rejectFrame || (wrState == W_DROP && !phyRxValid);
      flagSet                = 4'b0000;
      flagSet[ERR_RXERR]     = dropOnErr;
      flagSet[ERR_OVERFLOW]  = dropOnFull;
      flagSet[ERR_CRC]       = rejectFrame && !crcOk;
      flagSet[ERR_LENGTH]    = rejectFrame && !lenOk;
   end

   always_ff @(posedge clk) begin
      if (resetActive) begin
         wptrReg       <= '0;
         frameStartReg <= '0;
         nbytesReg     <= '0;
         ucastReg      <= 1'b0;
         bcastReg      <= 1'b0;
         mcastReg      <= 1'b0;
         dropCount     <= '0;
         errFlags      <= '0;
      end else begin
         if (startFrame) begin
            frameStartReg <= wptrReg;
            nbytesReg     <= '0;
            ucastReg      <= 1'b1;
            bcastReg      <= 1'b1;
            mcastReg      <= 1'b0;
         end
         if (storeByte) begin
            wptrReg <= ptr_t'(wptrReg + 1'b1);
            if (nbytesReg != '1) nbytesReg <= nbytesReg + 11'd1;
            if (nbytesReg < 11'd6) begin
               ucastReg <= ucastReg & hitVec[nbytesReg[2:0]];
               bcastReg <= bcastReg & (phyRxD == 8'hFF);
            end
            if (nbytesReg == 11'd0) mcastReg <= phyRxD[0];
         end
         if (rewind) wptrReg <= frameStartReg;
         // A clear on the same cycle as a drop discards that drop's bookkeeping.
         if (clearErrors) begin
            dropCount <= '0;
            errFlags  <= '0;
         end else begin
            errFlags <= errFlags | flagSet;
            if (countDrop && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (storeByte) bufMem[wptrReg] <= phyRxD;
      if (issueByte) bufQ <= bufMem[rptrReg];
   end

   // ---------------- descriptor FIFO ----------------
   always_ff @(posedge clk) begin
      if (acceptFrame) descMem[descWrIdx] <= '{start: frameStartReg, len: nbytesReg - 11'd4, cls: frameCls};
      descQ <= descMem[descRdIdx];
   end

   always_ff @(posedge clk) begin
      if (resetActive) begin
         descWrIdx <= '0;
         descRdIdx <= '0;
         descCount <= '0;
      end else begin
         if (acceptFrame) descWrIdx <= descWrIdx + 1'b1;
         if (popDesc)     descRdIdx <= descRdIdx + 1'b1;
         if (acceptFrame && !popDesc)      descCount <= descCount + 1'b1;
         else if (popDesc && !acceptFrame) descCount <= descCount - 1'b1;
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge clk) begin
      if (resetActive) rdState <= R_IDLE;
      else             rdState <= rdStateNext;
   end

   always_comb begin
      rdStateNext = rdState;
      case (rdState)
         R_IDLE:  if (descCount != '0) rdStateNext = R_SFD;
         R_SFD:   if (PortReady) rdStateNext = R_DATA;
         R_DATA:  if (remainingReg == '0) rdStateNext = R_GAP;
         R_GAP:   if (gapCount == 4'(IPG_CYCLES - 1)) rdStateNext = R_IDLE;
         default: rdStateNext = R_IDLE;
      endcase
   end

   always_comb begin
      issueSfd  = (rdState == R_SFD) && PortReady;
      issueByte = (rdState == R_DATA) && PortReady && remainingReg != '0;
      popDesc   = (rdState == R_GAP) && gapCount == 4'(IPG_CYCLES - 1);
   end

   // descQ is only trusted from R_SFD onward, one cycle after the head index settles.
   always_ff @(posedge clk) begin
      if (resetActive) begin
         rptrReg      <= '0;
         rbaseReg     <= '0;
         remainingReg <= '0;
         PacketInfo   <= '0;
         RxValid      <= 1'b0;
         rxSfdReg     <= 1'b0;
         gapCount     <= '0;
      end else begin
         RxValid  <= issueSfd || issueByte;
         rxSfdReg <= issueSfd;
         gapCount <= (rdState == R_GAP) ? gapCount + 4'd1 : 4'd0;
         if (rdState == R_SFD) begin
            rptrReg      <= descQ.start;
            remainingReg <= descQ.len;
            PacketInfo   <= {1'b0, descQ.cls};
         end
         if (issueByte) begin
            rptrReg      <= ptr_t'(rptrReg + 1'b1);
            remainingReg <= remainingReg - 11'd1;
         end
         if (popDesc) begin
            rbaseReg   <= rptrReg;
            PacketInfo <= '0;
         end
      end
   end

   assign RxD   = RxValid ? (rxSfdReg ? SFD_BYTE : bufQ) : 8'h00;
   assign RxErr = 1'b0;

endmodule
